// File: rtl/kbd_code_scan_display_pkg.sv
// Shared definitions for the PS/2 released-key capture and display scanner:
// protocol byte values, capture FSM encoding and a saturating counter helper.
package kbd_code_scan_display_pkg;

  // PS/2 set-2 break prefix and extended-key prefix bytes
  localparam logic [7:0] KBD_BREAK = 8'hF0;
  localparam logic [7:0] KBD_EXT   = 8'hE0;

  // Capture FSM: IDLE waits for a break prefix, BRK waits for the released key byte
  typedef enum logic [0:0] {
    CAP_IDLE = 1'b0,
    CAP_BRK  = 1'b1
  } cap_state_e;

  // Increment an 8-bit count, holding at 255 instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/kbd_code_scan_display_refresh.sv
// Digit refresh scanner: divides clk down to one slot every REFRESH_DIV cycles,
// steps the driven digit index round-robin and exposes the matching active-low
// one-hot enable pattern (unregistered; the top registers it with the data).
module seg_refresh_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                                       clk,
  input  logic                                       rst,
  output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] digit_sel_o,
  output logic [DIGITS-1:0]                          seg_pattern_o
);

  localparam int SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_d;
  logic             tc_s;

  assign tc_s = (cnt_q == CNT_W'(REFRESH_DIV - 1));

  // Next refresh count and digit index; digit advances on terminal count only
  always_comb begin
    cnt_d = cnt_q;
    sel_d = sel_q;
    if (tc_s) begin
      cnt_d = {CNT_W{1'b0}};
      if (sel_q == SEL_W'(DIGITS - 1)) begin
        sel_d = {SEL_W{1'b0}};
      end else begin
        sel_d = sel_q + SEL_W'(1);
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Refresh counter and digit index registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= {CNT_W{1'b0}};
      sel_q <= {SEL_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
    end
  end

  // Active-low one-hot pattern for the digit currently selected
  always_comb begin
    seg_pattern_o = {DIGITS{1'b1}};
    for (int i = 0; i < DIGITS; i++) begin
      if (sel_q == SEL_W'(i)) begin
        seg_pattern_o[i] = 1'b0;
      end else begin
        seg_pattern_o[i] = 1'b1;
      end
    end
  end

  assign digit_sel_o = sel_q;

endmodule

// File: rtl/kbd_code_scan_display.sv
// Released-key history display: decodes PS/2 break sequences (optional E0
// prefix), keeps the last DIGITS released keys newest-first, and time-
// multiplexes them onto an active-low digit enable bus with registered outputs.
module kbd_code_scan_display
  import kbd_code_scan_display_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_EMPTY = 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       valid_code_i,
  input  logic [7:0]                                 scan_code_in_i,
  input  logic                                       clear_i,
  output logic [7:0]                                 code_to_display_o,
  output logic                                       code_ext_o,
  output logic [DIGITS-1:0]                          seg_en_o,
  output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] digit_sel_o,
  output logic [7:0]                                 key_count_o
);

  localparam int SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  cap_state_e        state_q;
  cap_state_e        state_d;
  logic              ext_pend_q;
  logic              ext_pend_d;
  logic              push_s;

  logic [7:0]        entry_q [DIGITS];
  logic [DIGITS-1:0] ext_q;
  logic [DIGITS-1:0] valid_q;
  logic [7:0]        key_count_q;

  logic [SEL_W-1:0]  sel_s;
  logic [DIGITS-1:0] seg_pattern_s;
  logic [DIGITS-1:0] seg_next_s;

  logic [7:0]        code_q;
  logic              code_ext_q;
  logic [DIGITS-1:0] seg_en_q;

  seg_refresh_scan #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_scan (
    .clk           (clk),
    .rst           (rst),
    .digit_sel_o   (sel_s),
    .seg_pattern_o (seg_pattern_s)
  );

  // Capture FSM next state; clear wins over a simultaneous byte strobe
  always_comb begin
    state_d    = state_q;
    ext_pend_d = ext_pend_q;
    push_s     = 1'b0;
    if (clear_i) begin
      state_d    = CAP_IDLE;
      ext_pend_d = 1'b0;
    end else if (valid_code_i) begin
      case (state_q)
        CAP_IDLE: begin
          if (scan_code_in_i == KBD_EXT) begin
            ext_pend_d = 1'b1;
          end else if (scan_code_in_i == KBD_BREAK) begin
            state_d = CAP_BRK;
          end else begin
            // make code: any pending E0 belonged to a key press, not a release
            ext_pend_d = 1'b0;
          end
        end
        CAP_BRK: begin
          if (scan_code_in_i == KBD_EXT) begin
            ext_pend_d = 1'b1;
          end else if (scan_code_in_i == KBD_BREAK) begin
            state_d = CAP_BRK;
          end else begin
            push_s     = 1'b1;
            ext_pend_d = 1'b0;
            state_d    = CAP_IDLE;
          end
        end
        default: begin
          state_d    = CAP_IDLE;
          ext_pend_d = 1'b0;
        end
      endcase
    end else begin
      state_d    = state_q;
      ext_pend_d = ext_pend_q;
    end
  end

  // Capture FSM state and pending-extension flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= CAP_IDLE;
      ext_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ext_pend_q <= ext_pend_d;
    end
  end

  // History shift buffer: newest at index 0, oldest falls off the end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DIGITS; i++) begin
        entry_q[i] <= 8'h00;
      end
      ext_q   <= {DIGITS{1'b0}};
      valid_q <= {DIGITS{1'b0}};
    end else if (clear_i) begin
      for (int i = 0; i < DIGITS; i++) begin
        entry_q[i] <= 8'h00;
      end
      ext_q   <= {DIGITS{1'b0}};
      valid_q <= {DIGITS{1'b0}};
    end else if (push_s) begin
      for (int i = DIGITS - 1; i > 0; i--) begin
        entry_q[i] <= entry_q[i-1];
        ext_q[i]   <= ext_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
      entry_q[0] <= scan_code_in_i;
      ext_q[0]   <= ext_pend_q;
      valid_q[0] <= 1'b1;
    end else begin
      ext_q   <= ext_q;
      valid_q <= valid_q;
    end
  end

  // Released-key counter, saturating at 255
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_count_q <= 8'h00;
    end else if (clear_i) begin
      key_count_q <= 8'h00;
    end else if (push_s) begin
      key_count_q <= sat_inc8(key_count_q);
    end else begin
      key_count_q <= key_count_q;
    end
  end

  // Enable pattern for the selected slot, dark when that slot was never written
  always_comb begin
    seg_next_s = seg_pattern_s;
    if ((BLANK_EMPTY != 0) && !valid_q[sel_s]) begin
      seg_next_s = {DIGITS{1'b1}};
    end else begin
      seg_next_s = seg_pattern_s;
    end
  end

  // Display output registers: one cycle behind digit index and buffer contents
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_q     <= 8'h00;
      code_ext_q <= 1'b0;
      seg_en_q   <= {DIGITS{1'b1}};
    end else begin
      code_q     <= entry_q[sel_s];
      code_ext_q <= ext_q[sel_s];
      seg_en_q   <= seg_next_s;
    end
  end

  assign code_to_display_o = code_q;
  assign code_ext_o        = code_ext_q;
  assign seg_en_o          = seg_en_q;
  assign digit_sel_o       = sel_s;
  assign key_count_o       = key_count_q;

endmodule

// File: tb/tb_kbd_code_scan_display.sv
// Scoreboard bench for kbd_code_scan_display (DIGITS=4, REFRESH_DIV=4).
// Stimulus pushes the expected per-digit display after each key sequence;
// a monitor pops an entry whenever the DUT is presenting that digit.
module tb_kbd_code_scan_display;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_code;
  logic [7:0] scan_code;
  logic       clear;
  logic [7:0] code_to_display;
  logic       code_ext;
  logic [3:0] seg_en;
  logic [1:0] digit_sel;
  logic [7:0] key_count;

  typedef struct {
    int         dig;
    logic [3:0] seg;
    logic [7:0] code;
    logic       ext;
    logic [7:0] kc;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   last_sel = 0;

  kbd_code_scan_display #(
    .DIGITS      (4),
    .REFRESH_DIV (4),
    .BLANK_EMPTY (1)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .valid_code_i      (valid_code),
    .scan_code_in_i    (scan_code),
    .clear_i           (clear),
    .code_to_display_o (code_to_display),
    .code_ext_o        (code_ext),
    .seg_en_o          (seg_en),
    .digit_sel_o       (digit_sel),
    .key_count_o       (key_count)
  );

  always #5 clk = ~clk;

  // Monitor: outputs at a negedge show the digit that was selected one cycle earlier
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      last_sel = 0;
    end else begin
      if (sb_q.size() > 0 && sb_q[0].dig == last_sel) begin
        e = sb_q.pop_front();
        total++;
        if (seg_en !== e.seg || code_to_display !== e.code ||
            code_ext !== e.ext || key_count !== e.kc) begin
          bad++;
          $display("FAIL disp_d%0d: got seg=%b code=%h ext=%b kc=%0d, want seg=%b code=%h ext=%b kc=%0d",
                   e.dig, seg_en, code_to_display, code_ext, key_count,
                   e.seg, e.code, e.ext, e.kc);
        end
      end
      last_sel = int'(digit_sel);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    valid_code = 1'b1;
    scan_code  = b;
    @(negedge clk);
    valid_code = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Queue the expected view of all four digits, then wait for the monitor to drain it
  task automatic expect_disp(input logic [7:0] c0, input logic [7:0] c1,
                             input logic [7:0] c2, input logic [7:0] c3,
                             input logic [3:0] ext, input logic [3:0] vld,
                             input logic [7:0] kc);
    logic [7:0] cs [4];
    exp_t e;
    int   n;
    cs[0] = c0; cs[1] = c1; cs[2] = c2; cs[3] = c3;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      e.dig  = d;
      e.seg  = 4'b1111;
      if (vld[d]) e.seg[d] = 1'b0;
      e.code = cs[d];
      e.ext  = ext[d];
      e.kc   = kc;
      sb_q.push_back(e);
    end
    n = 0;
    while (sb_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d entries left, want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b0;
    valid_code = 1'b0;
    scan_code  = 8'h00;
    clear      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg_en", 32'(seg_en), 32'h0000000F);
    chk("rst_code", 32'(code_to_display), 32'h0);
    chk("rst_ext", 32'(code_ext), 32'h0);
    chk("rst_kc", 32'(key_count), 32'h0);
    chk("rst_sel", 32'(digit_sel), 32'h0);
    rst = 1'b1;

    // Empty buffer: stays dark, digit index steps every 4 clocks
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (seg_en !== 4'b1111) begin
        total++;
        bad++;
        $display("FAIL idle_dark: got %b want 1111 at clk %0d", seg_en, k);
      end else begin
        total++;
      end
      if (k == 3)  chk("sel_k3", 32'(digit_sel), 32'd0);
      if (k == 4)  chk("sel_k4", 32'(digit_sel), 32'd1);
      if (k == 8)  chk("sel_k8", 32'(digit_sel), 32'd2);
      if (k == 12) chk("sel_k12", 32'(digit_sel), 32'd3);
      if (k == 16) chk("sel_k16", 32'(digit_sel), 32'd0);
    end

    // Make then release of 1C
    send(8'h1C); send(8'hF0); send(8'h1C);
    expect_disp(8'h1C, 8'h00, 8'h00, 8'h00, 4'b0000, 4'b0001, 8'd1);

    // Five releases after a clear; first one falls off the end
    pulse_clear();
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h32);
    send(8'hF0); send(8'h21); send(8'hF0); send(8'h23);
    send(8'hF0); send(8'h24);
    expect_disp(8'h24, 8'h23, 8'h21, 8'h32, 4'b0000, 4'b1111, 8'd5);

    // Extended release, then plain release
    send(8'hE0); send(8'hF0); send(8'h75);
    expect_disp(8'h75, 8'h24, 8'h23, 8'h21, 4'b0001, 4'b1111, 8'd6);
    send(8'hF0); send(8'h1C);
    expect_disp(8'h1C, 8'h75, 8'h24, 8'h23, 4'b0010, 4'b1111, 8'd7);

    // E0 on a make code must not leak into the following release
    send(8'hE0); send(8'h6B); send(8'hF0); send(8'h6B);
    expect_disp(8'h6B, 8'h1C, 8'h75, 8'h24, 8'b0100, 4'b1111, 8'd8);

    // Clear coinciding with the byte after F0 drops it
    pulse_clear();
    send(8'hF0);
    @(negedge clk);
    valid_code = 1'b1;
    scan_code  = 8'h1C;
    clear      = 1'b1;
    @(negedge clk);
    valid_code = 1'b0;
    clear      = 1'b0;
    expect_disp(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 4'b0000, 8'd0);
    send(8'h1C);
    expect_disp(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 4'b0000, 8'd0);
    send(8'hF0); send(8'h32);
    expect_disp(8'h32, 8'h00, 8'h00, 8'h00, 4'b0000, 4'b0001, 8'd1);

    // Reset after F0 discards the pending break
    send(8'hF0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    send(8'h1C);
    expect_disp(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 4'b0000, 8'd0);

    // 300 releases saturate the counter; last four codes 29..2C remain
    for (int i = 0; i < 300; i++) begin
      send(8'hF0);
      send(8'h01 + 8'(i % 64));
    end
    expect_disp(8'h2C, 8'h2B, 8'h2A, 8'h29, 4'b0000, 4'b1111, 8'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
